// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file responder.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_slv_state_t;

    localparam int APB_WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_slv_decode.sv
// Address window decode: maps a byte address to a register hit and word index.
module apb_slv_decode
    import apb_pkg::*;
#(
    parameter int                        APB_ADDR_WIDTH = 32,
    parameter int                        NUM_REGS       = 16,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = APB_ADDR_WIDTH'(32'h0000_0060),
    parameter int                        IDX_W          = $clog2(NUM_REGS)
) (
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
    output logic                      hit,
    output logic [IDX_W-1:0]          idx
);

    // One extra bit so the window span never wraps for small address widths.
    localparam logic [APB_ADDR_WIDTH:0] SPAN = (APB_ADDR_WIDTH+1)'(NUM_REGS * 4);

    logic [APB_ADDR_WIDTH-1:0] off;

    always_comb begin
        off = apb_paddr - BASE_ADDR;
        hit = ({1'b0, off} < SPAN);
        idx = off[2 +: IDX_W];
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB responder with a bank of read/write registers and optional wait states.
// Wait-state insertion is built only when APB_SLV_WAIT_EN is defined.
//
// state | meaning
// IDLE  | no transfer in progress, waiting for a setup cycle
// WAIT  | counting down inserted wait states (APB_SLV_WAIT_EN only)
// READY | apb_pready high, transfer completes on psel & penable
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                        APB_ADDR_WIDTH = 32,
    parameter int                        APB_DATA_WIDTH = 32,
    parameter int                        NUM_REGS       = 16,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = APB_ADDR_WIDTH'(32'h0000_0060),
    parameter int                        WAIT_STATES    = 2
) (
    input  logic                      apb_pclk,
    input  logic                      apb_prstn,
    input  logic                      apb_psel,
    input  logic                      apb_penable,
    input  logic                      apb_pwrite,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
    input  logic [APB_DATA_WIDTH-1:0] apb_wdata,
    output logic                      apb_pready,
    output logic [APB_DATA_WIDTH-1:0] apb_prdata
);

    localparam int IDX_W = $clog2(NUM_REGS);

    if (NUM_REGS < 2 || NUM_REGS > 256 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
        $error("NUM_REGS must be a power of two in 2..256");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("WAIT_STATES must be in 0..15");
    end

    apb_slv_state_t            state;
    apb_slv_state_t            state_d;
    logic                      hit;
    logic [IDX_W-1:0]          idx;
    logic                      wr_en;
    logic                      ready_d;
    logic [APB_DATA_WIDTH-1:0] prdata_d;
    logic [APB_DATA_WIDTH-1:0] regs [NUM_REGS];

`ifdef APB_SLV_WAIT_EN
    localparam logic [APB_WAIT_CNT_W-1:0] WAIT_INIT = APB_WAIT_CNT_W'(WAIT_STATES);
    logic [APB_WAIT_CNT_W-1:0] cnt;
    logic [APB_WAIT_CNT_W-1:0] cnt_d;
`endif

    apb_slv_decode #(
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .NUM_REGS       (NUM_REGS),
        .BASE_ADDR      (BASE_ADDR),
        .IDX_W          (IDX_W)
    ) u_decode (
        .apb_paddr (apb_paddr),
        .hit       (hit),
        .idx       (idx)
    );

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            state <= IDLE;
`ifdef APB_SLV_WAIT_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_d;
`ifdef APB_SLV_WAIT_EN
            cnt   <= cnt_d;
`endif
        end
    end

    // Dropping psel is a master abort from any state; a stray setup in WAIT/READY is ignored.
    always_comb begin
        state_d = state;
`ifdef APB_SLV_WAIT_EN
        cnt_d   = cnt;
`endif
        if (!apb_psel) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!apb_penable) begin
`ifdef APB_SLV_WAIT_EN
                        cnt_d   = WAIT_INIT;
                        state_d = (WAIT_INIT == '0) ? READY : WAIT;
`else
                        state_d = READY;
`endif
                    end
                end
`ifdef APB_SLV_WAIT_EN
                WAIT: begin
                    cnt_d = cnt - 1'b1;
                    if (cnt == APB_WAIT_CNT_W'(1)) begin
                        state_d = READY;
                    end
                end
`endif
                READY: begin
                    if (apb_penable) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read data is captured only on entry to READY and cleared whenever READY is left.
    always_comb begin
        wr_en    = (state == READY) && apb_psel && apb_penable && apb_pwrite && hit;
        ready_d  = (state_d == READY);
        prdata_d = apb_prdata;
        if (state_d != READY) begin
            prdata_d = '0;
        end else if (state != READY) begin
            prdata_d = (!apb_pwrite && hit) ? regs[idx] : '0;
        end
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            apb_pready <= 1'b0;
            apb_prdata <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            apb_pready <= ready_d;
            apb_prdata <= prdata_d;
            if (wr_en) begin
                regs[idx] <= apb_wdata;
            end
        end
    end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB responder holding a bank of 32-bit read/write registers, with a configurable number of wait states per access. It is the target on the APB side of the AHB-to-APB bridge, and it is the default peripheral model on that bridge's APB port at block and subsystem level. It decodes a word-aligned address window, completes every transfer with `apb_pready`, and returns registered read data on `apb_prdata`.

## Interface
- `APB_ADDR_WIDTH`, 32: address width.
- `APB_DATA_WIDTH`, 32: data and register width.
- `NUM_REGS`, 16: register count; must be a power of two, 2..256.
- `BASE_ADDR`, 32'h0000_0060: byte address of register 0.
- `WAIT_STATES`, 2: wait cycles inserted before `apb_pready`, range 0..15. Used only when `APB_SLV_WAIT_EN` is defined.
- `apb_pclk`, in, 1: the single clock. All logic is on the rising edge.
- `apb_prstn`, in, 1: reset. Asynchronous assert, active low.
- `apb_psel`, in, 1: slave select.
- `apb_penable`, in, 1: access phase.
- `apb_pwrite`, in, 1: 1 = write, 0 = read.
- `apb_paddr`, in, APB_ADDR_WIDTH: byte address.
- `apb_wdata`, in, APB_DATA_WIDTH: write data.
- `apb_pready`, out, 1: transfer complete. Registered.
- `apb_prdata`, out, APB_DATA_WIDTH: read data. Registered.

## Operation
- Decode:
  - `off = apb_paddr - BASE_ADDR` (unsigned, APB_ADDR_WIDTH bits).
  - Hit when `off < NUM_REGS*4`.
  - `idx = off[2 +: log2(NUM_REGS)]`; `off[1:0]` is ignored.
  - A miss is not an error. Writes are dropped and reads return 0.
- FSM states: IDLE, WAIT, READY. Reset state is IDLE.
  - IDLE: a setup cycle (`apb_psel=1`, `apb_penable=0`) moves to WAIT with `cnt=WAIT_STATES`. If the wait count is 0, it moves straight to READY.
  - WAIT: `cnt` decrements each cycle. When `cnt==1`, move to READY.
  - READY: `apb_pready=1`. At the completing edge (`psel & penable & pready`), a write to a hit commits `apb_wdata` to `reg[idx]`, and the FSM returns to IDLE.
  - Any state: `apb_psel=0` forces IDLE, clears `apb_pready`, and commits no write (master abort).
- Read data:
  - On the transition into READY with `apb_pwrite=0`, `apb_prdata` loads `reg[idx]` (or 0 on a miss).
  - Otherwise `apb_prdata` holds 0 outside READY.
- Address, write, and data are sampled from the bus as presented in the access phase. The master must hold them stable, as APB requires; the block does not latch them in setup.

## Timing
- Reset values: `apb_pready=0`, `apb_prdata=0`, all registers 0, FSM IDLE, `cnt=0`.
- Reset asserted mid-transfer aborts it immediately; no register is written.
- Effective wait count W: W = WAIT_STATES with the macro defined, W = 0 without it.
- Zero-wait: the setup edge enters READY, so `apb_pready=1` in the first access cycle. The transfer takes 2 pclk.
- W>0: `apb_pready` rises W cycles after the first access cycle. The transfer takes W+2 pclk.
- `apb_pready` is low in the cycle after completion.
- Back-to-back: a new setup may follow completion directly; it is accepted from IDLE on the next edge.
- A write followed by a read of the same register returns the new value.
- A setup seen while in WAIT or READY is a protocol violation and is ignored; `apb_psel` low is the only exit besides completion.

## Configuration
- Macro `APB_SLV_WAIT_EN`.
- Defined: the wait counter `cnt` (4 bits) and the WAIT state are built, and W = WAIT_STATES.
- Undefined: there is no counter and no WAIT state. IDLE goes directly to READY, so every transfer has zero wait states. `WAIT_STATES` is ignored.

## Structure
- Shared package `apb_pkg`:
  - FSM state enum `apb_slv_state_t` (IDLE, WAIT, READY).
  - Constant `APB_WAIT_CNT_W = 4`.
- Sub-module `apb_slv_decode` (combinational): computes hit and idx from `apb_paddr`, `BASE_ADDR`, and `NUM_REGS`. The FSM, counter, and register array stay in the top level.

## Test plan
- Reset, then idle: `apb_pready=0`, `apb_prdata=0`, and reads of regs 0..15 return 0.
- Write burst to 100, 104, 108, 112 with data 0x200/0x300/0x400/0x500 and WAIT_STATES=2: each `apb_pready` rises on the 3rd access cycle, and reg1..reg4 take those values.
- Read of 100 after the burst: `apb_prdata=0x200` in the `apb_pready` cycle, and 0 in the cycle after.
- Write 0xDEAD to 0x100 (miss), then read 0x100: the transfer completes normally, reads return 0, and no register changes.
- Drop `apb_psel` during WAIT of a write to 104: `apb_pready` never asserts and reg2 keeps its old value. A following write completes normally.
- With `APB_SLV_WAIT_EN` undefined: a write of 0x1234 to 96 shows `apb_pready=1` in the first access cycle, and reg0=0x1234.
